// File: rtl/prince_rand_pkg.sv
// Shared constants and types for the PRINCE mask-randomness scheduler.
package prince_rand_pkg;

  localparam int unsigned RAND_W  = 216;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned N_ROT   = 8;
  localparam int unsigned ROT_W   = 3;
  localparam int unsigned N_BYTES = RAND_W / BYTE_W;

  typedef logic [RAND_W-1:0] rand_vec_t;
  typedef logic [ROT_W-1:0]  rot_idx_t;

endpackage

// File: rtl/rand_byte_rotate.sv
// Combinational variable right-rotate by whole bytes.
//   din  : vector to rotate
//   rot  : rotation amount k in bytes (0 = identity)
//   dout : {din[8k-1:0], din[RAND_W-1:8k]}
module rand_byte_rotate
  import prince_rand_pkg::*;
(
  input  rand_vec_t din,
  input  rot_idx_t  rot,
  output rand_vec_t dout
);

  // Mux over the N_ROT constant rotations; k=0 reduces to din.
  always_comb begin
    dout = din;
    for (int unsigned k = 0; k < N_ROT; k++) begin
      if (rot == rot_idx_t'(k)) begin
        dout = (din >> (k * BYTE_W)) | (din << ((RAND_W - k * BYTE_W) % RAND_W));
      end
    end
  end

endmodule

// File: rtl/rand_rotation_scheduler.sv
// Serves each fresh randomness vector N_ROT times, byte-rotated by k=0..N_ROT-1,
// with a shadow buffer so the next vector loads in the background.
//   clk, rst_n   : clock, async active-low reset
//   flush        : sync pulse, discard all held randomness
//   fresh_rand   : fresh vector, with fresh_valid / fresh_ready handshake
//   stage_req    : pipeline asks for one stage's masks
//   stage_grant  : rand_out valid for this request (same cycle)
//   rand_out     : active vector rotated right by rot_idx bytes, 0 when empty
//   rot_idx      : current rotation index k
//   starved      : stage_req high while no active vector
module rand_rotation_scheduler
  import prince_rand_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      flush,
  input  rand_vec_t fresh_rand,
  input  logic      fresh_valid,
  output logic      fresh_ready,
  input  logic      stage_req,
  output logic      stage_grant,
  output rand_vec_t rand_out,
  output rot_idx_t  rot_idx,
  output logic      starved
);

  rand_vec_t active_reg, active_reg_nxt;
  rand_vec_t shadow_reg, shadow_reg_nxt;
  logic      active_vld, active_vld_nxt;
  logic      shadow_vld, shadow_vld_nxt;
  rot_idx_t  rot_q, rot_nxt;
  rand_vec_t rot_vec;
  logic      accept;
  logic      last;

  rand_byte_rotate u_rotate (
    .din  (active_reg),
    .rot  (rot_q),
    .dout (rot_vec)
  );

  // Handshakes and outputs, all combinational from state and inputs.
  always_comb begin
    fresh_ready = ~shadow_vld & ~flush;
    accept      = fresh_valid & fresh_ready;
    stage_grant = stage_req & active_vld & ~flush;
    starved     = stage_req & ~active_vld;
    last        = stage_grant & (rot_q == rot_idx_t'(N_ROT - 1));
    rand_out    = active_vld ? rot_vec : '0;
    rot_idx     = rot_q;
  end

  // Next state: flush dominates; exhaustion promotes the shadow; accept routes
  // to active when it is (or is about to be) empty and nothing is queued.
  always_comb begin
    active_reg_nxt = active_reg;
    shadow_reg_nxt = shadow_reg;
    active_vld_nxt = active_vld;
    shadow_vld_nxt = shadow_vld;
    rot_nxt        = rot_q;

    if (flush) begin
      active_reg_nxt = '0;
      shadow_reg_nxt = '0;
      active_vld_nxt = 1'b0;
      shadow_vld_nxt = 1'b0;
      rot_nxt        = '0;
    end else begin
      if (last) begin
        rot_nxt        = '0;
        active_reg_nxt = shadow_reg;
        active_vld_nxt = shadow_vld;
        shadow_vld_nxt = 1'b0;
      end else if (stage_grant) begin
        rot_nxt = rot_q + rot_idx_t'(1);
      end

      if (accept) begin
        if ((~active_vld | last) & ~shadow_vld) begin
          active_reg_nxt = fresh_rand;
          active_vld_nxt = 1'b1;
          rot_nxt        = '0;
        end else begin
          shadow_reg_nxt = fresh_rand;
          shadow_vld_nxt = 1'b1;
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_reg <= '0;
      shadow_reg <= '0;
      active_vld <= 1'b0;
      shadow_vld <= 1'b0;
      rot_q      <= '0;
    end else begin
      active_reg <= active_reg_nxt;
      shadow_reg <= shadow_reg_nxt;
      active_vld <= active_vld_nxt;
      shadow_vld <= shadow_vld_nxt;
      rot_q      <= rot_nxt;
    end
  end

endmodule

// File: tb/tb_rand_rotation_scheduler.sv
module tb_rand_rotation_scheduler;
  import prince_rand_pkg::*;

  logic      clk = 1'b0;
  logic      rst_n = 1'b0;
  logic      flush = 1'b0;
  rand_vec_t fresh_rand = '0;
  logic      fresh_valid = 1'b0;
  logic      fresh_ready;
  logic      stage_req = 1'b0;
  logic      stage_grant;
  rand_vec_t rand_out;
  rot_idx_t  rot_idx;
  logic      starved;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rand_rotation_scheduler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .fresh_rand  (fresh_rand),
    .fresh_valid (fresh_valid),
    .fresh_ready (fresh_ready),
    .stage_req   (stage_req),
    .stage_grant (stage_grant),
    .rand_out    (rand_out),
    .rot_idx     (rot_idx),
    .starved     (starved)
  );

  typedef struct {
    logic do_rst;
    logic fl;
    logic fv;
    int   sel;      // 0 none, 1 V, 2 W
    logic req;
    logic e_grant;
    int   e_rot;
    logic e_ready;
    logic e_starved;
    int   e_vec;    // 0 zero, 1 V rotated by e_rot, 2 W rotated by e_rot
  } row_t;

  row_t      tbl[$];
  rand_vec_t vec_v, vec_w;
  rand_vec_t hist[$];

  // Output byte j takes input byte (j+k) mod N_BYTES.
  function automatic rand_vec_t rot_bytes(rand_vec_t a, int k);
    rand_vec_t r;
    r = '0;
    for (int j = 0; j < int'(N_BYTES); j++)
      r[j*BYTE_W +: BYTE_W] = a[((j + k) % int'(N_BYTES))*BYTE_W +: BYTE_W];
    return r;
  endfunction

  function automatic rand_vec_t pick(int sel);
    if (sel == 1) return vec_v;
    if (sel == 2) return vec_w;
    return '0;
  endfunction

  task automatic chk(string name, rand_vec_t act, rand_vec_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_invariant();
    chk("shadow_implies_active", rand_vec_t'(dut.shadow_vld & ~dut.active_vld), '0);
  endtask

  task automatic add(logic r, logic fl, logic fv, int sel, logic req,
                     logic eg, int erot, logic erdy, logic est, int evec);
    row_t x;
    x.do_rst = r; x.fl = fl; x.fv = fv; x.sel = sel; x.req = req;
    x.e_grant = eg; x.e_rot = erot; x.e_ready = erdy; x.e_starved = est; x.e_vec = evec;
    tbl.push_back(x);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; flush = 1'b0; fresh_valid = 1'b0; stage_req = 1'b0; fresh_rand = '0;
    #1;
    chk("rst_grant",   rand_vec_t'(stage_grant), '0);
    chk("rst_out",     rand_out, '0);
    chk("rst_rot",     rand_vec_t'(rot_idx), '0);
    chk("rst_ready",   rand_vec_t'(fresh_ready), rand_vec_t'(1));
    chk("rst_starved", rand_vec_t'(starved), '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    hist.delete();
  endtask

  task automatic apply_row(row_t x);
    rand_vec_t e_out;
    if (x.do_rst) do_reset();
    @(negedge clk);
    flush = x.fl; fresh_valid = x.fv; fresh_rand = pick(x.sel); stage_req = x.req;
    #1;
    e_out = (x.e_vec == 0) ? '0 : rot_bytes(pick(x.e_vec), x.e_rot);
    chk("tbl_grant",   rand_vec_t'(stage_grant), rand_vec_t'(x.e_grant));
    chk("tbl_rot",     rand_vec_t'(rot_idx), rand_vec_t'(x.e_rot));
    chk("tbl_ready",   rand_vec_t'(fresh_ready), rand_vec_t'(x.e_ready));
    chk("tbl_starved", rand_vec_t'(starved), rand_vec_t'(x.e_starved));
    chk("tbl_out",     rand_out, e_out);
    chk_invariant();
  endtask

  // Behavioural reference: a FIFO of at most two held vectors plus the
  // number of rotations already served from the head.
  rand_vec_t mq[$];
  int        mk;

  task automatic rand_cycle();
    rand_vec_t r, e_out;
    logic      fl, fv, req, has, e_grant, e_ready, e_starved;
    bit        found;
    for (int i = 0; i < int'(N_BYTES); i++) r[i*BYTE_W +: BYTE_W] = 8'($urandom);
    fl  = ($urandom_range(0, 39) == 0);
    fv  = ($urandom_range(0, 1) == 1);
    req = ($urandom_range(0, 9) < 6);
    @(negedge clk);
    flush = fl; fresh_valid = fv; fresh_rand = r; stage_req = req;
    #1;
    has       = (mq.size() > 0);
    e_grant   = req && has && !fl;
    e_ready   = (mq.size() < 2) && !fl;
    e_starved = req && !has;
    e_out     = has ? rot_bytes(mq[0], mk) : '0;
    chk("rnd_grant",   rand_vec_t'(stage_grant), rand_vec_t'(e_grant));
    chk("rnd_rot",     rand_vec_t'(rot_idx), rand_vec_t'(mk));
    chk("rnd_ready",   rand_vec_t'(fresh_ready), rand_vec_t'(e_ready));
    chk("rnd_starved", rand_vec_t'(starved), rand_vec_t'(e_starved));
    chk("rnd_out",     rand_out, e_out);
    chk_invariant();
    if (stage_grant) begin
      found = 1'b0;
      foreach (hist[i]) if (hist[i] == rand_out) found = 1'b1;
      chk("no_reuse", rand_vec_t'(found), '0);
      hist.push_back(rand_out);
    end
    if (fl) begin
      mq.delete();
      mk = 0;
    end else begin
      if (e_grant) begin
        mk++;
        if (mk == int'(N_ROT)) begin
          void'(mq.pop_front());
          mk = 0;
        end
      end
      if (fv && e_ready) mq.push_back(r);
    end
  endtask

  initial begin
    for (int i = 0; i < int'(N_BYTES); i++) vec_v[i*BYTE_W +: BYTE_W] = 8'(i);
    vec_w = ~vec_v;

    // Empty start, load, full serve with background W, zero-gap swap, accept on last.
    add(1, 0, 0, 0, 1,  0, 0, 1, 1, 0);
    add(0, 0, 1, 1, 1,  0, 0, 1, 1, 0);
    for (int k = 0; k < 8; k++) add(0, 0, k == 1, 2, 1,  1, k, k <= 1, 0, 1);
    for (int k = 0; k < 8; k++) add(0, 0, k == 7, 1, 1,  1, k, 1, 0, 2);
    add(0, 0, 0, 0, 0,  0, 0, 1, 0, 1);
    add(0, 0, 0, 0, 0,  0, 0, 1, 0, 1);
    for (int k = 0; k < 8; k++) add(0, 0, 0, 0, 1,  1, k, 1, 0, 1);
    add(0, 0, 0, 0, 0,  0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 1,  0, 0, 1, 1, 0);
    // Flush at k=3 with shadow full and fresh_valid high.
    add(1, 0, 1, 1, 0,  0, 0, 1, 0, 0);
    add(0, 0, 1, 2, 1,  1, 0, 1, 0, 1);
    add(0, 0, 0, 0, 1,  1, 1, 0, 0, 1);
    add(0, 0, 0, 0, 1,  1, 2, 0, 0, 1);
    add(0, 1, 1, 2, 1,  0, 3, 0, 0, 1);
    add(0, 0, 0, 0, 1,  0, 0, 1, 1, 0);
    add(0, 0, 1, 2, 0,  0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 1,  1, 0, 1, 0, 2);

    foreach (tbl[i]) apply_row(tbl[i]);

    // Explicit byte spot-check at k=1.
    do_reset();
    @(negedge clk); fresh_valid = 1'b1; fresh_rand = vec_v; stage_req = 1'b0;
    @(negedge clk); fresh_valid = 1'b0; stage_req = 1'b1;
    @(negedge clk);
    #1;
    chk("k1_byte0",  rand_vec_t'(rand_out[7:0]), rand_vec_t'(8'h01));
    chk("k1_byte26", rand_vec_t'(rand_out[RAND_W-1 -: 8]), rand_vec_t'(8'h00));

    // Async reset mid-serve at k=5.
    do_reset();
    @(negedge clk); fresh_valid = 1'b1; fresh_rand = vec_v; stage_req = 1'b0;
    @(negedge clk); fresh_valid = 1'b0; stage_req = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    chk("pre_arst_rot",   rand_vec_t'(rot_idx), rand_vec_t'(5));
    chk("pre_arst_grant", rand_vec_t'(stage_grant), rand_vec_t'(1));
    #1 rst_n = 1'b0;
    #1;
    chk("arst_grant", rand_vec_t'(stage_grant), '0);
    chk("arst_out",   rand_out, '0);
    chk("arst_rot",   rand_vec_t'(rot_idx), '0);
    chk("arst_ready", rand_vec_t'(fresh_ready), rand_vec_t'(1));
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk("post_arst_ready",   rand_vec_t'(fresh_ready), rand_vec_t'(1));
    chk("post_arst_starved", rand_vec_t'(starved), rand_vec_t'(1));

    // Randomized run against the FIFO model.
    do_reset();
    mq.delete();
    mk = 0;
    repeat (3000) rand_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
